// File: rtl/game_round_ctl_if.sv
// Bus between the trigger/hit logic, duck controller, 7-segment mux and game_round_ctl.
// master drives the game events; slave is the round sequencer.
interface game_round_ctl_if;
    logic       new_frame;
    logic       start;
    logic       shot_fired;
    logic       hit;
    logic       duck_offscreen;
    logic       duck_launch;
    logic       duck_active;
    logic       duck_fall;
    logic [3:0] ammo;
    logic [3:0] ducks_hit;
    logic [3:0] duck_idx;
    logic [7:0] round_bcd;
    logic       game_over;

    modport master (
        output new_frame, start, shot_fired, hit, duck_offscreen,
        input  duck_launch, duck_active, duck_fall, ammo, ducks_hit,
               duck_idx, round_bcd, game_over
    );

    modport slave (
        input  new_frame, start, shot_fired, hit, duck_offscreen,
        output duck_launch, duck_active, duck_fall, ammo, ducks_hit,
               duck_idx, round_bcd, game_over
    );
endinterface

// File: rtl/game_round_ctl.sv
// Duck Hunt round sequencer: launches ducks, tracks ammo/hits, decides round advance or game over.
// Optional flight timeout is enabled by defining GAME_ROUND_CTL_TIMEOUT_EN.
module game_round_ctl #(
    parameter int AMMO_PER_DUCK   = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int FALL_FRAMES     = 60,
    parameter int ESCAPE_FRAMES   = 90,
    parameter int FLIGHT_FRAMES   = 300
) (
    input  logic            clk,
    input  logic            rst,
    game_round_ctl_if.slave bus
);

    localparam int MAX_PAUSE  = (FALL_FRAMES > ESCAPE_FRAMES) ? FALL_FRAMES : ESCAPE_FRAMES;
    localparam int MAX_FRAMES = (MAX_PAUSE > FLIGHT_FRAMES) ? MAX_PAUSE : FLIGHT_FRAMES;
    localparam int FCW        = $clog2(MAX_FRAMES + 1);

    localparam logic [FCW-1:0] FALL_LAST   = FCW'(FALL_FRAMES - 1);
    localparam logic [FCW-1:0] ESCAPE_LAST = FCW'(ESCAPE_FRAMES - 1);
`ifdef GAME_ROUND_CTL_TIMEOUT_EN
    localparam logic [FCW-1:0] FLIGHT_LAST = FCW'(FLIGHT_FRAMES - 1);
`endif
    localparam logic [3:0] AMMO_FULL = 4'(AMMO_PER_DUCK);
    localparam logic [3:0] LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0] PASS_MIN  = 4'(PASS_HITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FLIGHT,
        S_FALL,
        S_ESCAPE,
        S_TALLY,
        S_OVER
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [FCW-1:0] r_frameCnt;
    logic [FCW-1:0] w_frameCntNext;
    logic [3:0]     r_ammo;
    logic [3:0]     w_ammoNext;
    logic [3:0]     r_ducksHit;
    logic [3:0]     w_ducksHitNext;
    logic [3:0]     r_duckIdx;
    logic [3:0]     w_duckIdxNext;
    logic [7:0]     r_roundBcd;
    logic [7:0]     w_roundBcdNext;
    logic [7:0]     w_roundBcdInc;
    logic           r_duckLaunch;
    logic           r_duckActive;
    logic           r_duckFall;
    logic           r_gameOver;
    logic           w_timeout;

`ifdef GAME_ROUND_CTL_TIMEOUT_EN
    assign w_timeout = bus.new_frame && (r_frameCnt == FLIGHT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Two-digit BCD increment that sticks at 99.
    always_comb begin
        w_roundBcdInc = r_roundBcd;
        if (r_roundBcd == 8'h99) begin
            w_roundBcdInc = 8'h99;
        end else if (r_roundBcd[3:0] == 4'd9) begin
            w_roundBcdInc = {r_roundBcd[7:4] + 4'd1, 4'd0};
        end else begin
            w_roundBcdInc = {r_roundBcd[7:4], r_roundBcd[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_frameCntNext = r_frameCnt;
        w_ammoNext     = r_ammo;
        w_ducksHitNext = r_ducksHit;
        w_duckIdxNext  = r_duckIdx;
        w_roundBcdNext = r_roundBcd;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    w_nextState    = S_LAUNCH;
                    w_ducksHitNext = 4'd0;
                    w_duckIdxNext  = 4'd0;
                    w_roundBcdNext = 8'h01;
                end
            end
            S_LAUNCH: begin
                w_nextState = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (bus.shot_fired && (r_ammo != 4'd0)) begin
                    w_ammoNext = r_ammo - 4'd1;
                end
`ifdef GAME_ROUND_CTL_TIMEOUT_EN
                if (bus.new_frame) begin
                    w_frameCntNext = r_frameCnt + 1'b1;
                end
`endif
                // A hit beats ammo exhaustion, offscreen and timeout in the same cycle.
                if (bus.hit) begin
                    w_nextState    = S_FALL;
                    w_ducksHitNext = r_ducksHit + 4'd1;
                end else if ((bus.shot_fired && (r_ammo <= 4'd1)) ||
                             bus.duck_offscreen || w_timeout) begin
                    w_nextState = S_ESCAPE;
                end
            end
            S_FALL, S_ESCAPE: begin
                if (bus.new_frame) begin
                    if (r_frameCnt == ((r_state == S_FALL) ? FALL_LAST : ESCAPE_LAST)) begin
                        w_nextState = S_TALLY;
                    end else begin
                        w_frameCntNext = r_frameCnt + 1'b1;
                    end
                end
            end
            S_TALLY: begin
                if (r_duckIdx < LAST_DUCK) begin
                    w_nextState   = S_LAUNCH;
                    w_duckIdxNext = r_duckIdx + 4'd1;
                end else if (r_ducksHit >= PASS_MIN) begin
                    w_nextState    = S_LAUNCH;
                    w_roundBcdNext = w_roundBcdInc;
                    w_duckIdxNext  = 4'd0;
                    w_ducksHitNext = 4'd0;
                end else begin
                    w_nextState = S_OVER;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        // Every state change restarts the frame counter; a fresh duck gets a full magazine.
        if (w_nextState != r_state) begin
            w_frameCntNext = '0;
        end
        if (w_nextState == S_LAUNCH) begin
            w_ammoNext = AMMO_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frameCnt   <= '0;
            r_ammo       <= 4'd0;
            r_ducksHit   <= 4'd0;
            r_duckIdx    <= 4'd0;
            r_roundBcd   <= 8'h01;
            r_duckLaunch <= 1'b0;
            r_duckActive <= 1'b0;
            r_duckFall   <= 1'b0;
            r_gameOver   <= 1'b0;
        end else begin
            r_frameCnt   <= w_frameCntNext;
            r_ammo       <= w_ammoNext;
            r_ducksHit   <= w_ducksHitNext;
            r_duckIdx    <= w_duckIdxNext;
            r_roundBcd   <= w_roundBcdNext;
            r_duckLaunch <= (w_nextState == S_LAUNCH);
            r_duckActive <= (w_nextState == S_FLIGHT);
            r_duckFall   <= (w_nextState == S_FALL);
            r_gameOver   <= (w_nextState == S_OVER);
        end
    end

    assign bus.duck_launch = r_duckLaunch;
    assign bus.duck_active = r_duckActive;
    assign bus.duck_fall   = r_duckFall;
    assign bus.game_over   = r_gameOver;
    assign bus.ammo        = r_ammo;
    assign bus.ducks_hit   = r_ducksHit;
    assign bus.duck_idx    = r_duckIdx;
    assign bus.round_bcd   = r_roundBcd;

endmodule

// File: doc/game_round_ctl.md
# game_round_ctl

Round sequencer for Duck Hunt. It launches ducks one at a time, tracks ammo per duck and hits per round, and decides between round advance and game over. It sits in the control section between the trigger/hit logic and the duck controller. It also drives the ammo and round digits shown on the 7-segment mux.

## Interface
Parameters:
- AMMO_PER_DUCK, 3: shots available per duck (1..9).
- DUCKS_PER_ROUND, 10: ducks per round (1..15).
- PASS_HITS, 6: hits needed to clear a round (≤ DUCKS_PER_ROUND).
- FALL_FRAMES, 60: frames spent in FALL after a hit (≥1).
- ESCAPE_FRAMES, 90: frames spent in ESCAPE (≥1).
- FLIGHT_FRAMES, 300: flight timeout in frames (≥1). Used only with the macro.

Ports:
- clk, in, 1: 65 MHz system clock.
- rst, in, 1: asynchronous, active-low reset (asserted at 0).
- new_frame, in, 1: one-cycle pulse per video frame.
- start, in, 1: one-cycle start request.
- shot_fired, in, 1: one-cycle pulse, shot taken.
- hit, in, 1: one-cycle pulse, shot hit the duck.
- duck_offscreen, in, 1: level, duck has left the play area.
- duck_launch, out, 1: one-cycle pulse, duck controller loads a new duck.
- duck_active, out, 1: high in FLIGHT.
- duck_fall, out, 1: high in FALL.
- ammo, out, 4: remaining shots, binary 0..9, a direct hex digit.
- ducks_hit, out, 4: hits in the current round.
- duck_idx, out, 4: index of the current duck, 0-based.
- round_bcd, out, 8: round number as two BCD digits, {tens, ones}.
- game_over, out, 1: high in OVER.

## Operation
- FSM states: IDLE, LAUNCH, FLIGHT, FALL, ESCAPE, TALLY, OVER. All outputs are registered.
- Reset values: state=IDLE, ammo=0, ducks_hit=0, duck_idx=0, round_bcd=8'h01. All 1-bit outputs are 0.
- IDLE:
  - start → LAUNCH.
  - ducks_hit=0, duck_idx=0, round_bcd=01.
- LAUNCH (1 cycle):
  - duck_launch=1.
  - ammo loads AMMO_PER_DUCK.
  - → FLIGHT.
- FLIGHT:
  - shot_fired decrements ammo, saturating at 0.
  - hit increments ducks_hit → FALL. Hit takes priority over every other exit.
  - Otherwise, if shot_fired leaves ammo=0 → ESCAPE.
  - Otherwise, duck_offscreen=1 → ESCAPE.
  - hit and shot_fired in the same cycle: ammo decrements and the state goes to FALL.
  - hit outside FLIGHT is ignored. shot_fired outside FLIGHT is ignored.
- FALL / ESCAPE:
  - A frame counter is cleared on entry and increments on each new_frame.
  - Exit to TALLY on the FALL_FRAMES-th (or ESCAPE_FRAMES-th) new_frame pulse.
- TALLY (1 cycle):
  - If duck_idx < DUCKS_PER_ROUND−1: duck_idx++ → LAUNCH.
  - Else if ducks_hit ≥ PASS_HITS: round_bcd BCD-increments (saturates at 99); duck_idx=0; ducks_hit=0 → LAUNCH.
  - Else → OVER.
- OVER:
  - game_over=1. Counters hold their values for display.
  - start → LAUNCH, with ducks_hit=0, duck_idx=0, round_bcd=01.
- start is ignored in every state except IDLE and OVER.
- Reset mid-operation: asynchronous return to IDLE with the reset values above. Any in-flight pause is abandoned.

## Timing
- start at cycle N → LAUNCH at N+1, with duck_launch high during N+1. FLIGHT at N+2, with duck_active high.
- hit at cycle N in FLIGHT → ducks_hit updated and duck_fall high at N+1.
- FALL/ESCAPE exit: the state is TALLY the cycle after the qualifying new_frame. LAUNCH follows one cycle later.
- ammo updates the cycle after shot_fired.
- round_bcd updates at the TALLY→LAUNCH edge: 09→10, 99→99.
- Frame counter width: $clog2(max(FALL_FRAMES, ESCAPE_FRAMES, FLIGHT_FRAMES)+1).

## Configuration
- GAME_ROUND_CTL_TIMEOUT_EN defined:
  - FLIGHT runs a frame counter, cleared on FLIGHT entry.
  - On the FLIGHT_FRAMES-th new_frame with no hit → ESCAPE. ammo is unchanged.
  - hit in the same cycle as the timeout frame still wins → FALL.
- Not defined: no timeout. FLIGHT exits only on hit, ammo exhaustion or duck_offscreen. FLIGHT_FRAMES is unused.

## Test plan
- Reset, then start → duck_launch pulses once 1 cycle after start; ammo=3, round_bcd=01, duck_active=1.
- 3 shot_fired pulses without hit → ammo 2,1,0; ESCAPE after the 3rd shot; TALLY after 90 new_frame pulses; duck_idx=1.
- hit coincident with the 3rd shot → ammo=0, state FALL (not ESCAPE), ducks_hit=1; LAUNCH after 60 frames.
- 10 ducks with 6 hits → round_bcd=02, ducks_hit=0, duck_idx=0. With 5 hits → game_over=1; start then gives round_bcd=01, duck_launch.
- Force round 09 and clear it → round_bcd=8'h10. Force 99 and clear it → stays 8'h99.
- rst low mid-FALL → all outputs at reset values immediately. With GAME_ROUND_CTL_TIMEOUT_EN: 300 frames in FLIGHT with no shots → ESCAPE, ammo=3.
